// File: rtl/layer_mem_arb_pkg.sv
// Shared memory-interface widths and the arbiter state encoding.
// The widths may come from the command line; these are only defaults.
`ifndef LC_MEM_ADDR_WIDTH
`define LC_MEM_ADDR_WIDTH 8
`endif
`ifndef LC_MEM_DATA_WIDTH
`define LC_MEM_DATA_WIDTH 32
`endif
`ifndef LC_MEM_DEPTH
`define LC_MEM_DEPTH 192
`endif

package layer_mem_arb_pkg;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE   = 2'd0,
        MEM_ARB_ACCESS = 2'd1,
        MEM_ARB_ACK    = 2'd2
    } mem_arb_state_t;

endpackage

// File: rtl/layer_mem_array.sv
// Single-port synchronous SRAM model with a 1-cycle registered read; a foundry macro can replace it.
// The contents and the read register are never reset.
module layer_mem_array #(
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int DEPTH = 192
) (
    input  logic          CLK,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int IW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] idx;

    assign idx = addr[IW-1:0];

    always_ff @(posedge CLK) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/layer_mem_arb.sv
// Round-robin arbiter between ports A/B onto the local SRAM; ACK rises WAIT_STATES+2 cycles after REQ is sampled
// and holds until REQ is seen low. LAYER_MEM_WPROT_EN adds a write-protect window for port B.
`ifndef LC_MEM_ADDR_WIDTH
`define LC_MEM_ADDR_WIDTH 8
`endif
`ifndef LC_MEM_DATA_WIDTH
`define LC_MEM_DATA_WIDTH 32
`endif
`ifndef LC_MEM_DEPTH
`define LC_MEM_DEPTH 192
`endif

module layer_mem_arb
    import layer_mem_arb_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int ARB_WIDTH   = 4,
    parameter int MEM_DEPTH   = `LC_MEM_DEPTH
) (
    input  logic                          CLK,
    input  logic                          RESETn,
    input  logic                          A_REQ,
    input  logic                          A_WRITE,
    input  logic [`LC_MEM_ADDR_WIDTH-1:0] A_ADDR,
    input  logic [`LC_MEM_DATA_WIDTH-1:0] A_WDATA,
    output logic [`LC_MEM_DATA_WIDTH-1:0] A_RDATA,
    output logic                          A_ACK,
    input  logic                          B_REQ,
    input  logic                          B_WRITE,
    input  logic [`LC_MEM_ADDR_WIDTH-1:0] B_ADDR,
    input  logic [`LC_MEM_DATA_WIDTH-1:0] B_WDATA,
    output logic [`LC_MEM_DATA_WIDTH-1:0] B_RDATA,
    output logic                          B_ACK,
`ifdef LAYER_MEM_WPROT_EN
    input  logic [`LC_MEM_ADDR_WIDTH-1:0] WPROT_LO,
    input  logic [`LC_MEM_ADDR_WIDTH-1:0] WPROT_HI,
`endif
    output logic                          ERR_OOR,
    input  logic                          ERR_CLR
);

    localparam int AW = `LC_MEM_ADDR_WIDTH;
    localparam int DW = `LC_MEM_DATA_WIDTH;

    mem_arb_state_t state, state_nxt;

    logic                 last_b, g_b, g_write, g_oor, g_prot, issued;
    logic [AW-1:0]        g_addr;
    logic [DW-1:0]        g_wdata;
    logic [ARB_WIDTH-1:0] cnt;

    logic          a_ok, b_ok, grant_any, grant_b, g_req;
    logic          sel_write, sel_oor, sel_prot;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          at_issue, at_done;
    logic          mem_en, mem_we;
    logic [DW-1:0] mem_rdata;

    always_comb begin
        // A requester still holding REQ against its own ACK is not a new request.
        a_ok      = A_REQ & ~A_ACK;
        b_ok      = B_REQ & ~B_ACK;
        grant_any = a_ok | b_ok;
        grant_b   = b_ok & (~a_ok | ~last_b);
        sel_write = grant_b ? B_WRITE : A_WRITE;
        sel_addr  = grant_b ? B_ADDR  : A_ADDR;
        sel_wdata = grant_b ? B_WDATA : A_WDATA;
        sel_oor   = {1'b0, sel_addr} >= (AW+1)'(MEM_DEPTH);
        sel_prot  = 1'b0;
`ifdef LAYER_MEM_WPROT_EN
        sel_prot  = grant_b & B_WRITE & (B_ADDR >= WPROT_LO) & (B_ADDR <= WPROT_HI);
`endif
        g_req     = g_b ? B_REQ : A_REQ;
        at_issue  = (state == MEM_ARB_ACCESS) && (cnt == '0) && !issued;
        at_done   = (state == MEM_ARB_ACCESS) && issued;
        mem_en    = at_issue & ~g_oor;
        mem_we    = g_write & ~g_prot;

        state_nxt = state;
        case (state)
            MEM_ARB_IDLE:   if (grant_any) state_nxt = MEM_ARB_ACCESS;
            MEM_ARB_ACCESS: if (at_done)   state_nxt = MEM_ARB_ACK;
            MEM_ARB_ACK:    if (!g_req)    state_nxt = MEM_ARB_IDLE;
            default:                       state_nxt = MEM_ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= MEM_ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            last_b  <= 1'b1;
            g_b     <= 1'b0;
            g_write <= 1'b0;
            g_oor   <= 1'b0;
            g_prot  <= 1'b0;
            g_addr  <= '0;
            g_wdata <= '0;
            cnt     <= '0;
            issued  <= 1'b0;
            A_ACK   <= 1'b0;
            B_ACK   <= 1'b0;
            A_RDATA <= '0;
            B_RDATA <= '0;
        end else begin
            if (state == MEM_ARB_IDLE && grant_any) begin
                g_b     <= grant_b;
                last_b  <= grant_b;
                g_write <= sel_write;
                g_addr  <= sel_addr;
                g_wdata <= sel_wdata;
                g_oor   <= sel_oor;
                g_prot  <= sel_prot;
                cnt     <= ARB_WIDTH'(WAIT_STATES);
                issued  <= 1'b0;
            end
            if (state == MEM_ARB_ACCESS && !issued && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (at_issue) begin
                issued <= 1'b1;
            end
            // Array read data lands one cycle after issue, together with ACK.
            if (at_done) begin
                if (g_b) begin
                    B_ACK <= 1'b1;
                    if (g_oor)         B_RDATA <= '1;
                    else if (!g_write) B_RDATA <= mem_rdata;
                end else begin
                    A_ACK <= 1'b1;
                    if (g_oor)         A_RDATA <= '1;
                    else if (!g_write) A_RDATA <= mem_rdata;
                end
            end
            if (state == MEM_ARB_ACK && !g_req) begin
                A_ACK <= 1'b0;
                B_ACK <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ERR_OOR <= 1'b0;
        end else if (at_done && (g_oor || g_prot)) begin
            ERR_OOR <= 1'b1;
        end else if (ERR_CLR) begin
            ERR_OOR <= 1'b0;
        end
    end

    layer_mem_array #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (MEM_DEPTH)
    ) u_array (
        .CLK   (CLK),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (g_addr),
        .wdata (g_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_layer_mem_arb.sv
// Bench for layer_mem_arb: directed scenarios plus randomized traffic on both ports,
// checked by a queue-based scoreboard against a flat memory model.
`ifndef LC_MEM_ADDR_WIDTH
`define LC_MEM_ADDR_WIDTH 8
`endif
`ifndef LC_MEM_DATA_WIDTH
`define LC_MEM_DATA_WIDTH 32
`endif
`ifndef LC_MEM_DEPTH
`define LC_MEM_DEPTH 192
`endif

module tb_layer_mem_arb;

    localparam int WS    = 2;
    localparam int AW    = `LC_MEM_ADDR_WIDTH;
    localparam int DW    = `LC_MEM_DATA_WIDTH;
    localparam int DEPTH = `LC_MEM_DEPTH;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          A_REQ = 1'b0, A_WRITE = 1'b0, B_REQ = 1'b0, B_WRITE = 1'b0;
    logic [AW-1:0] A_ADDR = '0, B_ADDR = '0;
    logic [DW-1:0] A_WDATA = '0, B_WDATA = '0;
    logic [DW-1:0] A_RDATA, B_RDATA;
    logic          A_ACK, B_ACK, ERR_OOR;
    logic          ERR_CLR = 1'b0;
`ifdef LAYER_MEM_WPROT_EN
    logic [AW-1:0] WPROT_LO = AW'(16);
    logic [AW-1:0] WPROT_HI = AW'(31);
`endif

    always #5 CLK = ~CLK;

    layer_mem_arb #(
        .WAIT_STATES (WS),
        .ARB_WIDTH   (4),
        .MEM_DEPTH   (DEPTH)
    ) dut (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .A_REQ   (A_REQ),
        .A_WRITE (A_WRITE),
        .A_ADDR  (A_ADDR),
        .A_WDATA (A_WDATA),
        .A_RDATA (A_RDATA),
        .A_ACK   (A_ACK),
        .B_REQ   (B_REQ),
        .B_WRITE (B_WRITE),
        .B_ADDR  (B_ADDR),
        .B_WDATA (B_WDATA),
        .B_RDATA (B_RDATA),
        .B_ACK   (B_ACK),
`ifdef LAYER_MEM_WPROT_EN
        .WPROT_LO (WPROT_LO),
        .WPROT_HI (WPROT_HI),
`endif
        .ERR_OOR (ERR_OOR),
        .ERR_CLR (ERR_CLR)
    );

    typedef struct {
        logic [DW-1:0] rd;
        bit            chk_err;
    } exp_t;

    exp_t          qa[$];
    exp_t          qb[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mem_m [256];
    bit            written [256];
    logic [DW-1:0] last_rd [2];
    logic [DW-1:0] ones = '1;
    int            cyc = 0;
    int            order[$];
    int            a_fall_cyc = 0, b_rise_cyc = 0, b_rises = 0;
    logic          a_prev = 1'b0, b_prev = 1'b0;
    logic [DW-1:0] rd, rd_a, rd_b;
    int            lat, lat_a, lat_b;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic logic ack_of(input int p);
        return (p == 0) ? A_ACK : B_ACK;
    endfunction

    always @(posedge CLK) cyc++;

    // Monitor: every rising ACK consumes one scoreboard entry for that port.
    always begin
        exp_t e;
        @(posedge CLK);
        #1;
        if (A_ACK || B_ACK) chk("ack_overlap", {63'd0, A_ACK && B_ACK}, 64'd0);
        if (A_ACK && !a_prev) begin
            order.push_back(0);
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_ack: A_ACK=1, required no ACK");
            end else begin
                e = qa.pop_front();
                chk("a_rdata", 64'(A_RDATA), 64'(e.rd));
                if (e.chk_err) chk("a_err_oor", {63'd0, ERR_OOR}, 64'd1);
            end
        end
        if (!A_ACK && a_prev) a_fall_cyc = cyc;
        if (B_ACK && !b_prev) begin
            order.push_back(1);
            b_rises++;
            b_rise_cyc = cyc;
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_ack: B_ACK=1, required no ACK");
            end else begin
                e = qb.pop_front();
                chk("b_rdata", 64'(B_RDATA), 64'(e.rd));
                if (e.chk_err) chk("b_err_oor", {63'd0, ERR_OOR}, 64'd1);
            end
        end
        a_prev = A_ACK;
        b_prev = B_ACK;
    end

    // One full 4-phase transaction; the model predicts the response when it is issued.
    task automatic xact(input int p, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        output logic [DW-1:0] rdo, output int lato);
        exp_t e;
        bit   oor, prot;
        int   n;
        oor  = int'(addr) >= DEPTH;
        prot = 1'b0;
`ifdef LAYER_MEM_WPROT_EN
        prot = (p == 1) && wr && (int'(addr) >= 16) && (int'(addr) <= 31);
`endif
        e.chk_err = oor || prot;
        if (oor)      e.rd = '1;
        else if (!wr) e.rd = mem_m[addr];
        else          e.rd = last_rd[p];
        if (wr && !oor && !prot) begin
            mem_m[addr]   = wd;
            written[addr] = 1'b1;
        end
        last_rd[p] = e.rd;
        if (p == 0) qa.push_back(e); else qb.push_back(e);

        @(negedge CLK);
        if (p == 0) begin A_REQ = 1'b1; A_WRITE = wr; A_ADDR = addr; A_WDATA = wd; end
        else        begin B_REQ = 1'b1; B_WRITE = wr; B_ADDR = addr; B_WDATA = wd; end
        lato = 0;
        do begin @(posedge CLK); #1; lato++; end while (!ack_of(p) && lato < 200);
        if (!ack_of(p)) begin
            checks++; errors++;
            $display("FAIL ack_timeout port %0d: ACK=0 after %0d cycles, required 1", p, lato);
        end
        rdo = (p == 0) ? A_RDATA : B_RDATA;
        @(negedge CLK);
        if (p == 0) A_REQ = 1'b0; else B_REQ = 1'b0;
        ERR_CLR = 1'b0;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (ack_of(p) && n < 50);
        chk("ack_fall_edges", 64'(n), 64'd1);
    endtask

    task automatic rand_port(input int p);
        logic [DW-1:0] r;
        int            l, ai;
        bit            wr;
        for (int i = 0; i < 30; i++) begin
            ai = int'(2 * $urandom_range(0, 103)) + p;
            wr = ($urandom_range(0, 1) == 1) || (ai < DEPTH && !written[ai]);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            xact(p, wr, AW'(ai), $urandom, r, l);
        end
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESETn = 1'b0;
        @(negedge CLK);
        RESETn = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_a_ack", {63'd0, A_ACK}, 64'd0);
        chk("reset_b_ack", {63'd0, B_ACK}, 64'd0);
        chk("reset_a_rdata", 64'(A_RDATA), 64'd0);
        chk("reset_b_rdata", 64'(B_RDATA), 64'd0);
        chk("reset_err_oor", {63'd0, ERR_OOR}, 64'd0);
        @(negedge CLK);
        RESETn = 1'b1;

        xact(0, 1'b1, AW'(5), 32'hDEADBEEF, rd, lat);
        chk("a_write_latency", 64'(lat - 1), 64'(WS + 2));
        xact(0, 1'b0, AW'(5), '0, rd, lat);
        chk("a_read_latency", 64'(lat - 1), 64'(WS + 2));
        chk("a_read_data", 64'(rd), 64'h00000000DEADBEEF);
        chk("b_ack_quiet", 64'(b_rises), 64'd0);

        pulse_reset();
        order.delete();
        fork
            for (int i = 0; i < 3; i++) xact(0, 1'b1, AW'(32), DW'(i), rd_a, lat_a);
            for (int j = 0; j < 3; j++) xact(1, 1'b1, AW'(33), DW'(j + 8), rd_b, lat_b);
        join
        chk("rr_count", 64'(order.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < order.size()) chk("rr_order", 64'(order[i]), 64'(i % 2));

        fork
            xact(0, 1'b1, AW'(48), 32'h0000_3030, rd_a, lat_a);
            begin
                repeat (2) @(negedge CLK);
                xact(1, 1'b1, AW'(49), 32'h0000_3131, rd_b, lat_b);
            end
        join
        chk("b_grant_after_a_release", 64'(b_rise_cyc - a_fall_cyc), 64'(WS + 3));

        xact(1, 1'b0, AW'(DEPTH), '0, rd, lat);
        chk("oor_rdata", 64'(rd), 64'(ones));
        chk("oor_err_set", {63'd0, ERR_OOR}, 64'd1);
        @(negedge CLK);
        ERR_CLR = 1'b1;
        @(posedge CLK);
        #1;
        chk("err_cleared", {63'd0, ERR_OOR}, 64'd0);
        @(negedge CLK);
        xact(0, 1'b1, AW'(DEPTH + 3), 32'h1234, rd, lat);
        repeat (2) @(posedge CLK);
        #1;
        chk("err_set_beats_clr", {63'd0, ERR_OOR}, 64'd1);

        xact(0, 1'b1, AW'(7), 32'h1, rd, lat);
        @(negedge CLK);
        A_REQ = 1'b1; A_WRITE = 1'b1; A_ADDR = AW'(7); A_WDATA = 32'h22;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RESETn = 1'b0;
        #1;
        chk("abort_a_ack", {63'd0, A_ACK}, 64'd0);
        chk("abort_err_oor", {63'd0, ERR_OOR}, 64'd0);
        A_REQ = 1'b0;
        A_WRITE = 1'b0;
        @(negedge CLK);
        RESETn = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        xact(0, 1'b0, AW'(7), '0, rd, lat);
        chk("abort_write_lost", 64'(rd), 64'd1);

`ifdef LAYER_MEM_WPROT_EN
        xact(0, 1'b1, AW'(18), 32'h77, rd, lat);
        xact(1, 1'b1, AW'(18), 32'h55, rd, lat);
        chk("wprot_err", {63'd0, ERR_OOR}, 64'd1);
        xact(0, 1'b0, AW'(18), '0, rd, lat);
        chk("wprot_unchanged", 64'(rd), 64'h77);
        xact(0, 1'b1, AW'(18), 32'h99, rd, lat);
        xact(0, 1'b0, AW'(18), '0, rd, lat);
        chk("wprot_a_write", 64'(rd), 64'h99);
`endif

        fork
            rand_port(0);
            rand_port(1);
        join
        repeat (3) @(posedge CLK);
        #1;
        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_mem_arb.md
Name: layer_mem_arb

Overview:
- Memory target directly downstream of the layer controller's MEM_* interface.
- Owns the layer's local SRAM array.
- Arbitrates between two requesters:
  - Port A: layer controller, MBus-originated DMA.
  - Port B: local datapath, e.g. a sensor FIFO drain.
- Both ports use the same 4-phase REQ/ACK handshake; reads complete with data valid while ACK is high.

Parameters:
- WAIT_STATES, 2, extra CLK cycles between grant and ACK (0..15), models array access time.
- ARB_WIDTH, 4, width of the wait-state counter.
- MEM_DEPTH, `LC_MEM_DEPTH, number of words implemented; addresses at or above it are out of range.

Ports:
- CLK  input  1  block clock
- RESETn  input  1  asynchronous active-low reset
- A_REQ  input  1  port A request; level, held until A_ACK seen
- A_WRITE  input  1  port A: 1 write, 0 read; stable while A_REQ
- A_ADDR  input  `LC_MEM_ADDR_WIDTH  port A word address
- A_WDATA  input  `LC_MEM_DATA_WIDTH  port A write data
- A_RDATA  output  `LC_MEM_DATA_WIDTH  port A read data, valid while A_ACK
- A_ACK  output  1  port A acknowledge
- B_REQ, B_WRITE, B_ADDR, B_WDATA, B_RDATA, B_ACK  same as port A for port B
- ERR_OOR  output  1  sticky, set on any out-of-range access
- ERR_CLR  input  1  synchronous clear of ERR_OOR

Behaviour:
- Reset (asynchronous, RESETn low):
  - Outputs: A_ACK=0, B_ACK=0, A_RDATA=0, B_RDATA=0, ERR_OOR=0.
  - Internal: state=IDLE, last-grant=B (so A wins first tie), counter=0.
  - Array contents are not reset.
- States: IDLE, ACCESS, ACK.
- IDLE:
  - If only one REQ is high, grant that port.
  - If both are high, grant the port not granted last (round-robin).
  - On grant: latch port id, WRITE, ADDR, WDATA; counter=WAIT_STATES; go to ACCESS.
  - A REQ that is still high while its own ACK is high is never granted, which prevents double-trigger.
- ACCESS:
  - If counter≠0, decrement.
  - If counter=0, perform the access this cycle:
    - In range, write: array[addr] <= wdata.
    - In range, read: granted RDATA <= array[addr].
    - Out of range: no array write; RDATA <= all-ones; ERR_OOR <= 1.
  - Then assert the granted ACK (registered) and go to ACK.
- Latency: ACK rises WAIT_STATES+2 cycles after the REQ-high sampling edge.
- ACK state:
  - Hold ACK and RDATA until the granted REQ is sampled low.
  - Then deassert ACK and return to IDLE. The other port can be granted in that same cycle as IDLE (no extra bubble beyond IDLE).
- Upstream may drop REQ asynchronously on ACK. The block only requires REQ low at some CLK edge while in ACK.
- RDATA of the non-granted port is unchanged.
- ERR_CLR and a new OOR event in the same cycle: the set wins.
- REQ dropped during ACCESS (protocol violation): the access still completes. ACK pulses high for ≥1 cycle, then falls when REQ is low.
- Reset mid-access: the access is abandoned and any write not yet performed is lost. The upstream sees ACK=0 and must reissue.
- Address wrap is not performed: MEM_DEPTH-1 is the last valid word.

Optional Feature:
- Macro: LAYER_MEM_WPROT_EN.
- When defined:
  - Extra ports WPROT_LO and WPROT_HI (input, `LC_MEM_ADDR_WIDTH).
  - Port B writes with WPROT_LO ≤ addr ≤ WPROT_HI are suppressed: ACK still returned, ERR_OOR set.
  - Port A is never protected.
- When undefined: no extra ports; all in-range writes are performed.

Decomposition:
- Shared package/include (mbus_def): `LC_MEM_ADDR_WIDTH, `LC_MEM_DATA_WIDTH, `LC_MEM_DEPTH, plus new state encodings MEM_ARB_IDLE/ACCESS/ACK (2 bits).
- One sub-module: layer_mem_array, a single-port synchronous array (write enable, address, wdata, rdata with 1-cycle read), so it can be swapped for a foundry macro.
- Arbiter FSM and error logic stay in layer_mem_arb.

Test Plan:
- Port A write 0xDEADBEEF to addr 5, then read addr 5, with WAIT_STATES=2 -> A_ACK rises 4 cycles after REQ sampling; A_RDATA=0xDEADBEEF; B_ACK stays 0.
- A_REQ and B_REQ raised in the same cycle after reset, each reissued 3 times -> grants alternate A,B,A,B,A,B; no overlapping ACKs.
- Port B read of addr MEM_DEPTH -> B_RDATA=all-ones, ERR_OOR=1; pulse ERR_CLR -> ERR_OOR=0; ERR_CLR coincident with a new OOR access -> stays 1.
- Upstream drops A_REQ one cycle after A_ACK (async-clear style) -> A_ACK falls next edge; a pending B_REQ is granted that same cycle.
- RESETn pulsed low during ACCESS of a port A write to addr 7 (old value 0x1) -> A_ACK=0 immediately; array[7] still 0x1.
- With LAYER_MEM_WPROT_EN, WPROT 0x10..0x1F: B writes 0x55 to 0x12 -> B_ACK returned, array unchanged, ERR_OOR=1; A write to 0x12 succeeds.
